// File: rtl/alu_decode_stage_if.sv
// alu_decode_stage_if: handshake bundle for the ALU decode stage.
//   s_*   : upstream entry (decoded fields + register/immediate values), valid/ready
//   m_*   : downstream ALU control and operands, valid/ready
// Modports: slave  = the decode stage itself
//           master = the surrounding pipeline (register-file read side + execute side)
interface alu_decode_stage_if #(
  parameter int unsigned WIDTH = 32
);
  logic             s_valid;
  logic             s_ready;
  logic [6:0]       s_opcode;
  logic [2:0]       s_funct3;
  logic             s_funct7b5;
  logic [WIDTH-1:0] s_rs1;
  logic [WIDTH-1:0] s_rs2;
  logic [WIDTH-1:0] s_imm;

  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_a;
  logic [WIDTH-1:0] m_b;
  logic [2:0]       m_alu_control;
  logic             m_illegal;

  modport slave (
    input  s_valid, s_opcode, s_funct3, s_funct7b5, s_rs1, s_rs2, s_imm, m_ready,
    output s_ready, m_valid, m_a, m_b, m_alu_control, m_illegal
  );

  modport master (
    output s_valid, s_opcode, s_funct3, s_funct7b5, s_rs1, s_rs2, s_imm, m_ready,
    input  s_ready, m_valid, m_a, m_b, m_alu_control, m_illegal
  );
endinterface

// File: rtl/alu_decode_stage.sv
// alu_decode_stage: registered decode-to-execute stage. Decodes opcode/funct3/funct7b5 into
// the ALU operation code, selects operand B (rs2 or immediate) and registers the result
// behind a valid/ready handshake, absorbing execute-side backpressure and flushes.
// Ports:
//   clk    : rising-edge clock
//   resetn : asynchronous active-low reset
//   flush  : synchronous discard of held and incoming entries (highest priority)
//   bus    : alu_decode_stage_if.slave (s_* upstream, m_* downstream)
// Configuration macro: ALU_DECODE_SKID_EN
//   defined   : output register + skid register, s_ready is a pure register output
//   undefined : output register only, s_ready = ~m_valid | m_ready
module alu_decode_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               flush,
  alu_decode_stage_if.slave  bus
);

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluXor = 3'b011;
  localparam logic [2:0] AluSlt = 3'b101;
  localparam logic [2:0] AluOr  = 3'b110;
  localparam logic [2:0] AluBad = 3'b111;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       ctrl;
    logic             illegal;
  } entry_t;

  logic [2:0] dec_ctrl;
  logic       dec_illegal;
  logic       dec_use_imm;
  entry_t     in_entry;

  // Combinational decode; anything not recognised falls through as illegal with b = rs2.
  always_comb begin
    dec_ctrl    = AluBad;
    dec_illegal = 1'b1;
    dec_use_imm = 1'b0;
    case (bus.s_opcode)
      OpR, OpI: begin
        dec_illegal = 1'b0;
        case (bus.s_funct3)
          3'b000:  dec_ctrl = (bus.s_opcode == OpR && bus.s_funct7b5) ? AluSub : AluAdd;
          3'b111:  dec_ctrl = AluAnd;
          3'b100:  dec_ctrl = AluXor;
          3'b010:  dec_ctrl = AluSlt;
          3'b110:  dec_ctrl = AluOr;
          default: begin
            dec_ctrl    = AluBad;
            dec_illegal = 1'b1;
          end
        endcase
        dec_use_imm = (bus.s_opcode == OpI) && !dec_illegal;
      end
      OpLoad, OpStore: begin
        dec_ctrl    = AluAdd;
        dec_illegal = 1'b0;
        dec_use_imm = 1'b1;
      end
      OpBranch: begin
        case (bus.s_funct3)
          3'b000, 3'b001: begin
            dec_ctrl    = AluSub;
            dec_illegal = 1'b0;
          end
          3'b100, 3'b101: begin
            dec_ctrl    = AluSlt;
            dec_illegal = 1'b0;
          end
          default: ;
        endcase
      end
      default: ;
    endcase

    in_entry.a       = bus.s_rs1;
    in_entry.b       = dec_use_imm ? bus.s_imm : bus.s_rs2;
    in_entry.ctrl    = dec_ctrl;
    in_entry.illegal = dec_illegal;
  end

  logic   out_valid_q, out_valid_d;
  entry_t out_q, out_d;
  logic   s_ready;
  logic   in_fire;

`ifdef ALU_DECODE_SKID_EN
  logic   skid_valid_q, skid_valid_d;
  entry_t skid_q, skid_d;

  assign s_ready = ~skid_valid_q;
  assign in_fire = bus.s_valid & s_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_d        = out_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || bus.m_ready) begin
      // Output free this edge: skid entry is older, so it goes first. When the skid is
      // full s_ready is low, so no input can be accepted in the same cycle.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = in_fire;
        if (in_fire) out_d = in_entry;
      end
    end else if (in_fire) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
    end
  end
`else
  assign s_ready = ~out_valid_q | bus.m_ready;
  assign in_fire = bus.s_valid & s_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (s_ready) begin
      out_valid_d = in_fire;
      if (in_fire) out_d = in_entry;
    end
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign bus.s_ready       = s_ready;
  assign bus.m_valid       = out_valid_q;
  assign bus.m_a           = out_q.a;
  assign bus.m_b           = out_q.b;
  assign bus.m_alu_control = out_q.ctrl;
  assign bus.m_illegal     = out_q.illegal;

endmodule
